// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: multi-channel reset sequencer with bus register slave.
// Define RST_FAULT_RESET_EN to make a captured SoC fault reset all channels.
module rst_seq_ctrl #(
  parameter int RST_CH      = 4,
  parameter int STRETCH_DEF = 16,
  parameter int CW          = 16,
  parameter int XLEN        = 32,
  parameter int BUS_WIDTH   = 32,
  parameter int BUS_ACC_CNT = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [XLEN-1:0]                p_addr,
  input  logic                           p_w_rb,
  input  logic [$clog2(BUS_ACC_CNT)-1:0] p_acc,
  output logic [BUS_WIDTH-1:0]           p_rdata,
  input  logic [BUS_WIDTH-1:0]           p_wdata,
  input  logic                           p_req,
  output logic                           p_resp,
  output logic                           p_fault,
  input  logic                           rst_ib,
  output logic [RST_CH-1:0]              rst_ob,
  input  logic                           soc_fault,
  input  logic [7:0]                     soc_fault_cause,
  input  logic [XLEN-1:0]                soc_fault_addr
);

  localparam int CHW = (RST_CH > 1) ? $clog2(RST_CH) : 1;
  localparam int AW  = $clog2(BUS_ACC_CNT);

  localparam logic [1:0] SRC_POR   = 2'd0;
  localparam logic [1:0] SRC_EXT   = 2'd1;
  localparam logic [1:0] SRC_SW    = 2'd2;
  localparam logic [1:0] SRC_FAULT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASRT,
    S_SEQ
  } st_t;

  st_t               state;
  logic              ext_s1;
  logic              ext_n;
  logic [RST_CH-1:0] released;
  logic [RST_CH-1:0] hold;
  logic [RST_CH-1:0] sw_act;
  logic [CW-1:0]     sw_cnt [RST_CH];
  logic [CW-1:0]     stretch;
  logic [CW-1:0]     s_lat;
  logic [CW-1:0]     cnt;
  logic [CHW-1:0]    ch;
  logic [7:0]        cause;
  logic              fvalid;
  logic [XLEN-1:0]   faddr;
  logic [1:0]        src;

  logic [4:0]           a;
  logic                 legal;
  logic                 wr;
  logic                 fv_clr;
  logic                 sw_wr;
  logic                 fault_acc;
  logic                 evt;
  logic [CW-1:0]        s_eff;
  logic [BUS_WIDTH-1:0] rdata;
  logic                 unused;

  assign unused = ^{p_addr, p_wdata};

  assign a      = p_addr[4:0];
  assign legal  = (p_acc == AW'(2)) && (a[1:0] == 2'b00)
                  && (a < 5'h14);
  assign wr     = p_req && p_w_rb && legal;
  assign fv_clr = wr && (a == 5'h08) && p_wdata[8];
  assign sw_wr  = wr && (a == 5'h00)
                  && (|p_wdata[RST_CH-1:0]);
  assign s_eff  = (stretch == '0) ? CW'(1) : stretch;

  // capture wins over a coincident clear of FVALID
  assign fault_acc = soc_fault && (!fvalid || fv_clr);

`ifdef RST_FAULT_RESET_EN
  assign evt = !ext_n || fault_acc;
`else
  assign evt = !ext_n;
`endif

  assign rst_ob = released & ~hold & ~sw_act;

  always_comb begin
    rdata = '0;
    case (a)
      5'h04:   rdata = BUS_WIDTH'(hold);
      5'h08:   rdata = BUS_WIDTH'({src, fvalid, cause});
      5'h0C:   rdata = BUS_WIDTH'(faddr);
      5'h10:   rdata = BUS_WIDTH'(stretch);
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ext_s1   <= 1'b1;
      ext_n    <= 1'b1;
      state    <= S_ASRT;
      released <= '0;
      hold     <= '0;
      sw_act   <= '0;
      for (int k = 0; k < RST_CH; k++)
        sw_cnt[k] <= '0;
      stretch  <= CW'(STRETCH_DEF);
      s_lat    <= '0;
      cnt      <= '0;
      ch       <= '0;
      cause    <= '0;
      fvalid   <= 1'b0;
      faddr    <= '0;
      src      <= SRC_POR;
      p_resp   <= 1'b0;
      p_fault  <= 1'b0;
      p_rdata  <= '0;
    end else begin
      ext_s1  <= rst_ib;
      ext_n   <= ext_s1;
      p_resp  <= p_req;
      p_fault <= p_req && !legal;
      p_rdata <= (p_req && legal && !p_w_rb) ? rdata : '0;

      if (wr && (a == 5'h04))
        hold <= p_wdata[RST_CH-1:0];
      if (wr && (a == 5'h10))
        stretch <= p_wdata[CW-1:0];

      if (fault_acc) begin
        cause  <= soc_fault_cause;
        faddr  <= soc_fault_addr;
        fvalid <= 1'b1;
      end else if (fv_clr) begin
        fvalid <= 1'b0;
      end

      for (int k = 0; k < RST_CH; k++) begin
        if (sw_act[k]) begin
          if (sw_cnt[k] >= s_eff)
            sw_act[k] <= 1'b0;
          else
            sw_cnt[k] <= sw_cnt[k] + CW'(1);
        end
      end

      unique case (state)
        S_IDLE: begin
          if (evt) begin
            state    <= S_ASRT;
            released <= '0;
            sw_act   <= '0;
            src      <= ext_n ? SRC_FAULT : SRC_EXT;
          end else if (sw_wr) begin
            for (int k = 0; k < RST_CH; k++) begin
              if (p_wdata[k]) begin
                sw_act[k] <= 1'b1;
                sw_cnt[k] <= CW'(1);
              end
            end
            src <= SRC_SW;
          end
        end
        S_ASRT: begin
          if (evt) begin
            src <= ext_n ? SRC_FAULT : SRC_EXT;
          end else begin
            state <= S_SEQ;
            cnt   <= CW'(1);
            ch    <= '0;
            s_lat <= s_eff;
          end
        end
        S_SEQ: begin
          if (evt) begin
            state    <= S_ASRT;
            released <= '0;
            sw_act   <= '0;
            src      <= ext_n ? SRC_FAULT : SRC_EXT;
          end else if (cnt >= s_lat) begin
            released[ch] <= 1'b1;
            cnt          <= CW'(1);
            if (ch == CHW'(RST_CH - 1))
              state <= S_IDLE;
            else
              ch <= ch + CHW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_ASRT;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed, table and random checks of rst_seq_ctrl
// against a time-based reference model of the release schedule.
module tb_rst_seq_ctrl;

  localparam int RST_CH = 4;
  localparam int STRETCH_DEF = 16;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic [31:0]       p_addr;
  logic              p_w_rb;
  logic [1:0]        p_acc;
  logic [31:0]       p_rdata;
  logic [31:0]       p_wdata;
  logic              p_req;
  logic              p_resp;
  logic              p_fault;
  logic              rst_ib;
  logic [RST_CH-1:0] rst_ob;
  logic              soc_fault;
  logic [7:0]        soc_fault_cause;
  logic [31:0]       soc_fault_addr;

  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .RST_CH(RST_CH),
    .STRETCH_DEF(STRETCH_DEF),
    .CW(CW),
    .XLEN(32),
    .BUS_WIDTH(32),
    .BUS_ACC_CNT(4)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .p_addr(p_addr),
    .p_w_rb(p_w_rb),
    .p_acc(p_acc),
    .p_rdata(p_rdata),
    .p_wdata(p_wdata),
    .p_req(p_req),
    .p_resp(p_resp),
    .p_fault(p_fault),
    .rst_ib(rst_ib),
    .rst_ob(rst_ob),
    .soc_fault(soc_fault),
    .soc_fault_cause(soc_fault_cause),
    .soc_fault_addr(soc_fault_addr)
  );

  int checks = 0;
  int errors = 0;
  int t = 0;

  function automatic void chk(string nm,
                              logic [31:0] got,
                              logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0d)",
               nm, got, exp, t);
    end
  endfunction

  // Reference model: release times derived from when the event ended.
  int              seq_start = 0;
  int              s_seq = 1;
  int              seff;
  bit              in_evt = 1'b1;
  int              sw_end [RST_CH];
  logic [RST_CH-1:0] m_hold;
  logic [CW-1:0]   m_str;
  logic            m_fv;
  logic [7:0]      m_cause;
  logic [31:0]     m_faddr;
  logic [1:0]      m_src;
  logic            m_sa = 1'b1;
  logic            m_sb = 1'b1;
  logic            ext_pre;
  logic [4:0]      ma;
  logic            m_legal, m_wr, m_clr, m_facc, m_evt, m_idle;
  logic [RST_CH-1:0] m_ob = '0;
  logic            m_resp = 1'b0;
  logic            m_fault = 1'b0;
  logic [31:0]     m_rdata = '0;

  function automatic logic [31:0] regval(logic [4:0] ad);
    case (ad)
      5'h04:   return 32'(m_hold);
      5'h08:   return {21'd0, m_src, m_fv, m_cause};
      5'h0C:   return m_faddr;
      5'h10:   return 32'(m_str);
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    t = t + 1;
    if (!rstn) begin
      m_hold = '0; m_str = CW'(STRETCH_DEF);
      m_fv = 1'b0; m_cause = '0; m_faddr = '0;
      m_src = 2'd0; in_evt = 1'b1;
      m_sa = 1'b1; m_sb = 1'b1;
      for (int k = 0; k < RST_CH; k++) sw_end[k] = 0;
      m_resp = 1'b0; m_fault = 1'b0; m_rdata = '0;
      m_ob = '0;
    end else begin
      ext_pre = m_sb;
      m_sb = m_sa;
      m_sa = rst_ib;
      ma = p_addr[4:0];
      m_legal = (p_acc == 2'd2) && (ma[1:0] == 2'b00)
                && (ma < 5'h14);
      m_wr = p_req && p_w_rb && m_legal;
      m_clr = m_wr && (ma == 5'h08) && p_wdata[8];
      m_facc = soc_fault && (!m_fv || m_clr);
      m_evt = !ext_pre;
`ifdef RST_FAULT_RESET_EN
      m_evt = m_evt || m_facc;
`endif
      seff = (m_str == 0) ? 1 : int'(m_str);
      m_idle = !in_evt && (t > seq_start + RST_CH * s_seq);
      m_resp = p_req;
      m_fault = p_req && !m_legal;
      m_rdata = (p_req && m_legal && !p_w_rb) ? regval(ma) : 0;
      if (m_evt) begin
        in_evt = 1'b1;
        for (int k = 0; k < RST_CH; k++) sw_end[k] = 0;
        m_src = ext_pre ? 2'd3 : 2'd1;
      end else if (in_evt) begin
        in_evt = 1'b0;
        seq_start = t;
        s_seq = seff;
      end else if (m_idle && m_wr && ma == 5'h00
                   && p_wdata[RST_CH-1:0] != 0) begin
        for (int k = 0; k < RST_CH; k++)
          if (p_wdata[k]) sw_end[k] = t + seff;
        m_src = 2'd2;
      end
      if (m_wr && ma == 5'h04) m_hold = p_wdata[RST_CH-1:0];
      if (m_wr && ma == 5'h10) m_str = p_wdata[CW-1:0];
      if (m_facc) begin
        m_fv = 1'b1;
        m_cause = soc_fault_cause;
        m_faddr = soc_fault_addr;
      end else if (m_clr) begin
        m_fv = 1'b0;
      end
      for (int k = 0; k < RST_CH; k++)
        m_ob[k] = !in_evt && (t >= seq_start + (k + 1) * s_seq)
                  && !m_hold[k] && !(t < sw_end[k]);
    end
  end

  always @(negedge clk) begin
    if (t > 0) begin
      chk("m_rst_ob", 32'(rst_ob), 32'(m_ob));
      chk("m_p_resp", 32'(p_resp), 32'(m_resp));
      chk("m_p_fault", 32'(p_fault), 32'(m_fault));
      chk("m_p_rdata", p_rdata, m_rdata);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus(input logic w, input logic [4:0] ad,
                     input logic [31:0] d, input logic [1:0] acc,
                     output logic [31:0] rd, output logic rs,
                     output logic fl);
    p_req = 1'b1; p_w_rb = w; p_addr = {27'd0, ad};
    p_wdata = d; p_acc = acc;
    @(posedge clk);
    #1;
    rs = p_resp; fl = p_fault; rd = p_rdata;
    p_req = 1'b0; p_w_rb = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [4:0]  ad;
    logic [1:0]  acc;
    logic [31:0] d;
    logic        ef;
    logic [31:0] er;
    string       nm;
  } vec_t;

  vec_t tbl [16];

  logic [31:0] rd;
  logic        rs, fl;
  logic [31:0] st_exp;
  int          r, sel, ib_low;
  logic [4:0]  aa;

  initial begin
    tbl[0]  = '{1'b0, 5'h04, 2'd2, 32'h0, 1'b0, 32'h0, "rd_hold"};
    tbl[1]  = '{1'b0, 5'h10, 2'd2, 32'h0, 1'b0, 32'd16, "rd_str"};
    tbl[2]  = '{1'b0, 5'h08, 2'd2, 32'h0, 1'b0, 32'h0, "rd_stat"};
    tbl[3]  = '{1'b0, 5'h0C, 2'd2, 32'h0, 1'b0, 32'h0, "rd_faddr"};
    tbl[4]  = '{1'b0, 5'h00, 2'd2, 32'h0, 1'b0, 32'h0, "rd_swrst"};
    tbl[5]  = '{1'b0, 5'h08, 2'd0, 32'h0, 1'b1, 32'h0, "rd_byte"};
    tbl[6]  = '{1'b0, 5'h14, 2'd2, 32'h0, 1'b1, 32'h0, "rd_oor"};
    tbl[7]  = '{1'b0, 5'h06, 2'd2, 32'h0, 1'b1, 32'h0, "rd_unal"};
    tbl[8]  = '{1'b1, 5'h10, 2'd2, 32'd3, 1'b0, 32'h0, "wr_str"};
    tbl[9]  = '{1'b1, 5'h10, 2'd1, 32'd7, 1'b1, 32'h0, "wr_half"};
    tbl[10] = '{1'b1, 5'h14, 2'd2, 32'hFFFF_FFFF, 1'b1, 32'h0, "wr_oor"};
    tbl[11] = '{1'b0, 5'h10, 2'd2, 32'h0, 1'b0, 32'd3, "rd_str3"};
    tbl[12] = '{1'b1, 5'h04, 2'd2, 32'h5, 1'b0, 32'h0, "wr_hold"};
    tbl[13] = '{1'b0, 5'h04, 2'd2, 32'h0, 1'b0, 32'h5, "rd_hold5"};
    tbl[14] = '{1'b1, 5'h04, 2'd2, 32'h0, 1'b0, 32'h0, "wr_hold0"};
    tbl[15] = '{1'b1, 5'h00, 2'd0, 32'hF, 1'b1, 32'h0, "wr_swbyte"};

    rstn = 1'b0; rst_ib = 1'b1;
    p_req = 1'b0; p_w_rb = 1'b0; p_addr = '0;
    p_acc = 2'd2; p_wdata = '0;
    soc_fault = 1'b0; soc_fault_cause = '0; soc_fault_addr = '0;
    ib_low = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ob_rst", 32'(rst_ob), 32'h0);
    chk("resp_rst", 32'(p_resp), 32'h0);
    chk("fault_rst", 32'(p_fault), 32'h0);
    chk("rdata_rst", p_rdata, 32'h0);

    rstn = 1'b1;
    for (int e = 0; e <= 64; e++) begin
      @(posedge clk);
      #1;
      if (e == 15) chk("por_15", 32'(rst_ob), 32'h0);
      if (e == 16) chk("por_16", 32'(rst_ob), 32'h1);
      if (e == 32) chk("por_32", 32'(rst_ob), 32'h3);
      if (e == 47) chk("por_47", 32'(rst_ob), 32'h3);
      if (e == 48) chk("por_48", 32'(rst_ob), 32'h7);
      if (e == 64) chk("por_64", 32'(rst_ob), 32'hF);
    end

    for (int i = 0; i < 16; i++) begin
      bus(tbl[i].w, tbl[i].ad, tbl[i].d, tbl[i].acc, rd, rs, fl);
      chk({tbl[i].nm, "_resp"}, 32'(rs), 32'h1);
      chk({tbl[i].nm, "_flt"}, 32'(fl), 32'(tbl[i].ef));
      chk({tbl[i].nm, "_data"}, rd, tbl[i].er);
    end

    // external reset pulse, stretch 3
    rst_ib = 1'b0;
    cyc(5);
    chk("ext_low", 32'(rst_ob), 32'h0);
    rst_ib = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      cyc(1);
      if (j == 5)  chk("ext_j5", 32'(rst_ob), 32'h0);
      if (j == 6)  chk("ext_j6", 32'(rst_ob), 32'h1);
      if (j == 9)  chk("ext_j9", 32'(rst_ob), 32'h3);
      if (j == 14) chk("ext_j14", 32'(rst_ob), 32'h7);
      if (j == 15) chk("ext_j15", 32'(rst_ob), 32'hF);
    end
    bus(1'b0, 5'h08, 32'h0, 2'd2, rd, rs, fl);
    chk("stat_ext", rd, 32'h200);

    // software reset of channel 2 with restart
    bus(1'b1, 5'h00, 32'h4, 2'd2, rd, rs, fl);
    chk("sw_w0", 32'(rst_ob), 32'hB);
    cyc(1);
    chk("sw_w1", 32'(rst_ob), 32'hB);
    bus(1'b1, 5'h00, 32'h4, 2'd2, rd, rs, fl);
    chk("sw_w2", 32'(rst_ob), 32'hB);
    cyc(1);
    chk("sw_w3", 32'(rst_ob), 32'hB);
    cyc(1);
    chk("sw_w4", 32'(rst_ob), 32'hB);
    cyc(1);
    chk("sw_w5", 32'(rst_ob), 32'hF);
    bus(1'b0, 5'h08, 32'h0, 2'd2, rd, rs, fl);
    chk("stat_sw", rd, 32'h400);

    // hold channel 0 through a reset sequence
    bus(1'b1, 5'h04, 32'h1, 2'd2, rd, rs, fl);
    rst_ib = 1'b0;
    cyc(4);
    rst_ib = 1'b1;
    cyc(20);
    chk("hold_seq", 32'(rst_ob), 32'hE);
    bus(1'b1, 5'h04, 32'h0, 2'd2, rd, rs, fl);
    chk("hold_clr", 32'(rst_ob), 32'hF);

    // fault capture
    soc_fault = 1'b1; soc_fault_cause = 8'h5A;
    soc_fault_addr = 32'h8000_0010;
    cyc(1);
    soc_fault = 1'b0;
`ifdef RST_FAULT_RESET_EN
    chk("flt_ob", 32'(rst_ob), 32'h0);
    st_exp = 32'h75A;
`else
    chk("flt_ob", 32'(rst_ob), 32'hF);
    st_exp = 32'h35A;
`endif
    cyc(3);
    soc_fault = 1'b1; soc_fault_cause = 8'h11;
    soc_fault_addr = 32'h1234_5678;
    cyc(1);
    soc_fault = 1'b0;
    cyc(20);
    bus(1'b0, 5'h08, 32'h0, 2'd2, rd, rs, fl);
    chk("stat_flt", rd, st_exp);
    bus(1'b0, 5'h0C, 32'h0, 2'd2, rd, rs, fl);
    chk("faddr", rd, 32'h8000_0010);

    soc_fault = 1'b1; soc_fault_cause = 8'h33;
    soc_fault_addr = 32'hA0;
    bus(1'b1, 5'h08, 32'h100, 2'd2, rd, rs, fl);
    soc_fault = 1'b0;
    cyc(20);
    bus(1'b0, 5'h08, 32'h0, 2'd2, rd, rs, fl);
    chk("stat_coin", rd, {st_exp[31:8], 8'h33});
    bus(1'b1, 5'h08, 32'h100, 2'd2, rd, rs, fl);
    bus(1'b0, 5'h08, 32'h0, 2'd2, rd, rs, fl);
    chk("stat_w1c", rd, {st_exp[31:9], 1'b0, 8'h33});

    // STRETCH of 0 behaves as 1
    bus(1'b1, 5'h10, 32'h0, 2'd2, rd, rs, fl);
    bus(1'b0, 5'h10, 32'h0, 2'd2, rd, rs, fl);
    chk("str0_rd", rd, 32'h0);
    bus(1'b1, 5'h00, 32'h2, 2'd2, rd, rs, fl);
    chk("str0_w0", 32'(rst_ob), 32'hD);
    cyc(1);
    chk("str0_w1", 32'(rst_ob), 32'hF);
    bus(1'b1, 5'h10, 32'h3, 2'd2, rd, rs, fl);

    // random traffic against the model; STRETCH stays at 3
    for (int i = 0; i < 900; i++) begin
      p_req = 1'b0; p_w_rb = 1'b0;
      r = int'($urandom_range(0, 99));
      if (r < 40) begin
        sel = int'($urandom_range(0, 6));
        case (sel)
          0: aa = 5'h00;
          1: aa = 5'h04;
          2: aa = 5'h08;
          3: aa = 5'h0C;
          4: aa = 5'h10;
          5: aa = 5'h14;
          default: aa = 5'h06;
        endcase
        p_addr = {27'd0, aa};
        p_acc = ($urandom_range(0, 9) == 0) ?
                2'($urandom_range(0, 3)) : 2'd2;
        p_w_rb = 1'($urandom_range(0, 1));
        if (aa == 5'h10) p_w_rb = 1'b0;
        p_wdata = $urandom;
        p_req = 1'b1;
      end
      soc_fault = ($urandom_range(0, 24) == 0);
      soc_fault_cause = 8'($urandom);
      soc_fault_addr = $urandom;
      if (ib_low > 0) begin
        rst_ib = 1'b0;
        ib_low--;
      end else begin
        rst_ib = 1'b1;
        if ($urandom_range(0, 59) == 0)
          ib_low = int'($urandom_range(1, 6));
      end
      cyc(1);
    end
    p_req = 1'b0; p_w_rb = 1'b0;
    soc_fault = 1'b0; rst_ib = 1'b1;
    cyc(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
